// File: rtl/top_ram_arbiter.sv
// Two-writer / two-reader round-robin arbiter in front of a simple dual-port RAM
// with a two-clock read latency. A read is held back for a cycle when it targets
// the address being written in the same cycle. Read responses come back in
// accept order, tagged with the requester id.
module top_ram_arbiter #(
  parameter int TOPSIZEWIDTH = 10,
  parameter int TOPWIDTH     = 32,
  parameter int RD_LAT       = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              wr_valid,
  output logic [1:0]              wr_ready,
  input  logic [TOPSIZEWIDTH-1:0] wr_addr0,
  input  logic [TOPSIZEWIDTH-1:0] wr_addr1,
  input  logic [TOPWIDTH-1:0]     wr_data0,
  input  logic [TOPWIDTH-1:0]     wr_data1,
  input  logic [1:0]              rd_valid_req,
  output logic [1:0]              rd_ready,
  input  logic [TOPSIZEWIDTH-1:0] rd_addr0,
  input  logic [TOPSIZEWIDTH-1:0] rd_addr1,
  output logic                    rd_valid,
  output logic                    rd_id,
  output logic [TOPWIDTH-1:0]     rd_data,
  output logic                    ram_wren,
  output logic [TOPSIZEWIDTH-1:0] ram_wraddress,
  output logic [TOPWIDTH-1:0]     ram_data,
  output logic [TOPSIZEWIDTH-1:0] ram_rdaddress,
  input  logic [TOPWIDTH-1:0]     ram_q
);

  logic              wr_pri_r;
  logic              rd_pri_r;
  logic [1:0]        wr_gnt_s;
  logic [1:0]        rd_elig_s;
  logic [1:0]        rd_gnt_s;
  logic [RD_LAT-1:0] pipe_v_r;
  logic [RD_LAT-1:0] pipe_id_r;

  // Write-port round-robin grant and RAM write-side mux.
  always_comb begin
    wr_gnt_s = 2'b00;
    if (reset) begin
      wr_gnt_s = 2'b00;
    end else if (wr_valid == 2'b11) begin
      wr_gnt_s = wr_pri_r ? 2'b10 : 2'b01;
    end else begin
      wr_gnt_s = wr_valid;
    end
    wr_ready      = wr_gnt_s;
    ram_wren      = |(wr_valid & wr_gnt_s);
    ram_wraddress = wr_gnt_s[1] ? wr_addr1 : wr_addr0;
    ram_data      = wr_gnt_s[1] ? wr_data1 : wr_data0;
  end

  // Read-port grant: drop readers colliding with this cycle's write, then round-robin.
  always_comb begin
    rd_elig_s    = rd_valid_req;
    rd_gnt_s     = 2'b00;
    rd_elig_s[0] = rd_valid_req[0] & ~(ram_wren & (rd_addr0 == ram_wraddress));
    rd_elig_s[1] = rd_valid_req[1] & ~(ram_wren & (rd_addr1 == ram_wraddress));
    if (reset) begin
      rd_gnt_s = 2'b00;
    end else if (rd_elig_s == 2'b11) begin
      rd_gnt_s = rd_pri_r ? 2'b10 : 2'b01;
    end else begin
      rd_gnt_s = rd_elig_s;
    end
    rd_ready      = rd_gnt_s;
    ram_rdaddress = rd_gnt_s[1] ? rd_addr1 : rd_addr0;
  end

  // Priority pointers flip only after a real two-way contention; latency pipe tracks accepts.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_pri_r  <= 1'b0;
      rd_pri_r  <= 1'b0;
      pipe_v_r  <= '0;
      pipe_id_r <= '0;
    end else begin
      if (wr_valid == 2'b11) begin
        wr_pri_r <= ~wr_pri_r;
      end else begin
        wr_pri_r <= wr_pri_r;
      end
      if (rd_elig_s == 2'b11) begin
        rd_pri_r <= ~rd_pri_r;
      end else begin
        rd_pri_r <= rd_pri_r;
      end
      pipe_v_r  <= {pipe_v_r[RD_LAT-2:0], |rd_gnt_s};
      pipe_id_r <= {pipe_id_r[RD_LAT-2:0], rd_gnt_s[1]};
    end
  end

  // Response outputs: forced quiet while reset is asserted.
  always_comb begin
    rd_valid = pipe_v_r[RD_LAT-1] & ~reset;
    rd_id    = pipe_id_r[RD_LAT-1] & ~reset;
    rd_data  = ram_q;
  end

endmodule

// File: tb/tb_top_ram_arbiter.sv
// Directed bench for top_ram_arbiter with a behavioural two-clock RAM and a
// response scoreboard keyed on the expected arrival cycle.
module tb_top_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  wr_valid;
  logic [1:0]  wr_ready;
  logic [9:0]  wr_addr0, wr_addr1;
  logic [31:0] wr_data0, wr_data1;
  logic [1:0]  rd_valid_req;
  logic [1:0]  rd_ready;
  logic [9:0]  rd_addr0, rd_addr1;
  logic        rd_valid;
  logic        rd_id;
  logic [31:0] rd_data;
  logic        ram_wren;
  logic [9:0]  ram_wraddress;
  logic [31:0] ram_data;
  logic [9:0]  ram_rdaddress;
  logic [31:0] ram_q;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic        id;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];
  logic [9:0]  ra_r;
  logic [31:0] q_r;

  top_ram_arbiter #(.TOPSIZEWIDTH(10), .TOPWIDTH(32), .RD_LAT(2)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .rd_valid_req(rd_valid_req), .rd_ready(rd_ready),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
    .ram_wren(ram_wren), .ram_wraddress(ram_wraddress), .ram_data(ram_data),
    .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Cycle counter used to time expected responses.
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural RAM: registered read address, registered output.
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    ra_r <= ram_rdaddress;
    q_r  <= mem[ra_r];
  end
  assign ram_q = q_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: a response is due exactly when the scoreboard head says so.
  always @(negedge clock) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("rsp_valid", {63'd0, rd_valid}, 64'd1);
      chk("rsp_id", {63'd0, rd_id}, {63'd0, e.id});
      chk("rsp_data", {32'd0, rd_data}, {32'd0, e.data});
    end else begin
      chk("rsp_idle", {63'd0, rd_valid}, 64'd0);
    end
  end

  task automatic step(input string tag, input logic rst,
                      input logic [1:0] wv, input logic [9:0] wa0, input logic [31:0] wd0,
                      input logic [9:0] wa1, input logic [31:0] wd1,
                      input logic [1:0] rv, input logic [9:0] ra0, input logic [9:0] ra1,
                      input logic [1:0] ew, input logic [1:0] er);
    reset = rst;
    wr_valid = wv; wr_addr0 = wa0; wr_data0 = wd0; wr_addr1 = wa1; wr_data1 = wd1;
    rd_valid_req = rv; rd_addr0 = ra0; rd_addr1 = ra1;
    if (rst) sbq.delete();
    @(negedge clock);
    chk({tag, ":wr_ready"}, {62'd0, wr_ready}, {62'd0, ew});
    chk({tag, ":rd_ready"}, {62'd0, rd_ready}, {62'd0, er});
    chk({tag, ":ram_wren"}, {63'd0, ram_wren}, {63'd0, |ew});
    if (ew != 2'b00) begin
      chk({tag, ":wraddr"}, {54'd0, ram_wraddress}, {54'd0, (ew[1] ? wa1 : wa0)});
      chk({tag, ":wrdata"}, {32'd0, ram_data}, {32'd0, (ew[1] ? wd1 : wd0)});
    end
    if (er != 2'b00) begin
      chk({tag, ":rdaddr"}, {54'd0, ram_rdaddress}, {54'd0, (er[1] ? ra1 : ra0)});
      sbq.push_back('{due: cyc + 2, id: er[1], data: shadow[er[1] ? ra1 : ra0]});
    end
    if (rst) begin
      chk({tag, ":rst_rd_valid"}, {63'd0, rd_valid}, 64'd0);
      chk({tag, ":rst_rd_id"}, {63'd0, rd_id}, 64'd0);
    end
    if (ew != 2'b00) shadow[ew[1] ? wa1 : wa0] = ew[1] ? wd1 : wd0;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0, 2'b00, 10'h0, 10'h0, 2'b00, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'd0;
      shadow[i] = 32'd0;
    end
    // Reset with every requester valid: no grants, no write, no response.
    step("rst0", 1'b1, 2'b11, 10'h001, 32'h1, 10'h002, 32'h2, 2'b11, 10'h003, 10'h004, 2'b00, 2'b00);
    step("rst1", 1'b1, 2'b11, 10'h001, 32'h1, 10'h002, 32'h2, 2'b11, 10'h003, 10'h004, 2'b00, 2'b00);
    idle("idle0");

    // Single write then read by requester 1.
    step("t1_wr", 1'b0, 2'b01, 10'h005, 32'hDEADBEEF, 10'h0, 32'h0, 2'b00, 10'h0, 10'h0, 2'b01, 2'b00);
    step("t1_rd", 1'b0, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0, 2'b10, 10'h0, 10'h005, 2'b00, 2'b10);
    idle("t1_i0");
    idle("t1_i1");

    // Write contention: grants alternate 0,1,0,1; losers hold their request.
    step("t2_w0", 1'b0, 2'b11, 10'h010, 32'hA0A0_0001, 10'h020, 32'hB0B0_0001, 2'b00, 10'h0, 10'h0, 2'b01, 2'b00);
    step("t2_w1", 1'b0, 2'b11, 10'h010, 32'hA0A0_0002, 10'h020, 32'hB0B0_0001, 2'b00, 10'h0, 10'h0, 2'b10, 2'b00);
    step("t2_w2", 1'b0, 2'b11, 10'h010, 32'hA0A0_0002, 10'h020, 32'hB0B0_0002, 2'b00, 10'h0, 10'h0, 2'b01, 2'b00);
    step("t2_w3", 1'b0, 2'b11, 10'h010, 32'hA0A0_0003, 10'h020, 32'hB0B0_0002, 2'b00, 10'h0, 10'h0, 2'b10, 2'b00);
    step("t2_w4", 1'b0, 2'b01, 10'h010, 32'hA0A0_0003, 10'h0, 32'h0, 2'b00, 10'h0, 10'h0, 2'b01, 2'b00);
    // Read contention: responses alternate id 0,1,0,1.
    step("t2_r0", 1'b0, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0, 2'b11, 10'h010, 10'h020, 2'b00, 2'b01);
    step("t2_r1", 1'b0, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0, 2'b11, 10'h010, 10'h020, 2'b00, 2'b10);
    step("t2_r2", 1'b0, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0, 2'b11, 10'h010, 10'h020, 2'b00, 2'b01);
    step("t2_r3", 1'b0, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0, 2'b11, 10'h010, 10'h020, 2'b00, 2'b10);
    idle("t2_i0");
    idle("t2_i1");

    // Hazard at the top address: read held one cycle, then returns new data.
    step("t3_hz", 1'b0, 2'b01, 10'h3FF, 32'h12345678, 10'h0, 32'h0, 2'b01, 10'h3FF, 10'h0, 2'b01, 2'b00);
    step("t3_rd", 1'b0, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0, 2'b01, 10'h3FF, 10'h0, 2'b00, 2'b01);
    idle("t3_i0");
    idle("t3_i1");

    // Hazard bypass: rd1 taken while rd0 collides; rd_pri must still favour rd0.
    step("t4_hz", 1'b0, 2'b01, 10'h040, 32'h0BADF00D, 10'h0, 32'h0, 2'b11, 10'h040, 10'h041, 2'b01, 2'b10);
    step("t4_rd0", 1'b0, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0, 2'b01, 10'h040, 10'h0, 2'b00, 2'b01);
    step("t4_pri0", 1'b0, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0, 2'b11, 10'h005, 10'h3FF, 2'b00, 2'b01);
    step("t4_pri1", 1'b0, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0, 2'b11, 10'h005, 10'h3FF, 2'b00, 2'b10);
    idle("t4_i0");
    idle("t4_i1");

    // Reset mid-read: both pointers advanced, read in flight, then one reset cycle.
    step("t5_acc", 1'b0, 2'b11, 10'h100, 32'h11110000, 10'h101, 32'h22220000, 2'b11, 10'h010, 10'h020, 2'b01, 2'b01);
    step("t5_rst", 1'b1, 2'b11, 10'h100, 32'h11110000, 10'h101, 32'h22220000, 2'b11, 10'h010, 10'h020, 2'b00, 2'b00);
    step("t5_pri", 1'b0, 2'b11, 10'h100, 32'h11110000, 10'h101, 32'h22220000, 2'b11, 10'h010, 10'h020, 2'b01, 2'b01);
    idle("t5_i0");
    idle("t5_i1");

    // Streaming: preload 0x000-0x007, then eight back-to-back reads by rd0.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("t6_wr%0d", i), 1'b0, 2'b01, 10'(i), 32'hA5000000 + 32'(i), 10'h0, 32'h0,
           2'b00, 10'h0, 10'h0, 2'b01, 2'b00);
    end
    for (int i = 0; i < 8; i++) begin
      step($sformatf("t6_rd%0d", i), 1'b0, 2'b00, 10'h0, 32'h0, 10'h0, 32'h0,
           2'b01, 10'(i), 10'h0, 2'b00, 2'b01);
    end
    for (int i = 0; i < 4; i++) idle($sformatf("drain%0d", i));

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
